// File: rtl/lb_cmd_bridge.sv
// Byte-stream to local-bus master bridge.
// Receives opcode/address/data command frames on an 8-bit input stream, issues one
// local-bus read or write per frame, waits for completion (with timeout) and returns
// a response frame on an 8-bit output stream. All outputs are registered.
module lb_cmd_bridge #(
    parameter int LB_DATA_W      = 32,
    parameter int LB_ADDR_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_rdy,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_rdy,
    output logic                 lb_wr_en,
    output logic                 lb_rd_en,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [LB_DATA_W-1:0] lb_wr_data,
    input  logic                 lb_wr_valid,
    input  logic                 lb_rd_valid,
    input  logic [LB_DATA_W-1:0] lb_rd_data,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam int AB   = LB_ADDR_W / 8;
    localparam int DB   = LB_DATA_W / 8;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [7:0]      AB_LAST = 8'(AB - 1);
    localparam logic [7:0]      DB_LAST = 8'(DB - 1);
    localparam logic [7:0]      DB_CNT  = 8'(DB);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_WR  = 8'h4B;
    localparam logic [7:0] RSP_RD  = 8'h44;
    localparam logic [7:0] RSP_TO  = 8'h54;
    localparam logic [7:0] RSP_BAD = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StIssue,
        StWait,
        StResp
    } state_t;

    state_t                state;
    logic                  is_wr;
    logic [7:0]            byte_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [LB_DATA_W-1:0]  resp_sr;
    // Number of response bytes still to send after the one currently on tx_data.
    logic [7:0]            resp_left;
    logic                  rx_fire;
    logic                  tx_fire;
    logic [7:0]            err_inc;

    assign rx_fire = rx_valid && rx_rdy;
    assign tx_fire = tx_valid && tx_rdy;
    assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Frame parser, bus sequencer and response serializer in one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            is_wr      <= 1'b0;
            byte_cnt   <= '0;
            to_cnt     <= '0;
            resp_sr    <= '0;
            resp_left  <= '0;
            rx_rdy     <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            lb_wr_en   <= 1'b0;
            lb_rd_en   <= 1'b0;
            lb_addr    <= '0;
            lb_wr_data <= '0;
            busy       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            // Strobes are single-cycle; only the ADDR/DATA exits raise them.
            lb_wr_en <= 1'b0;
            lb_rd_en <= 1'b0;
            case (state)
                StIdle: begin
                    rx_rdy <= 1'b1;
                    busy   <= 1'b0;
                    if (rx_fire) begin
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            is_wr <= (rx_data == OP_WR);
                            state <= StAddr;
                        end else begin
                            rx_rdy    <= 1'b0;
                            tx_valid  <= 1'b1;
                            tx_data   <= RSP_BAD;
                            resp_left <= '0;
                            err_cnt   <= err_inc;
                            state     <= StResp;
                        end
                    end
                end

                StAddr: begin
                    if (rx_fire) begin
                        lb_addr <= LB_ADDR_W'({lb_addr, rx_data});
                        if (byte_cnt == AB_LAST) begin
                            byte_cnt <= '0;
                            if (is_wr) begin
                                state <= StData;
                            end else begin
                                rx_rdy   <= 1'b0;
                                lb_rd_en <= 1'b1;
                                state    <= StIssue;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end

                StData: begin
                    if (rx_fire) begin
                        lb_wr_data <= LB_DATA_W'({lb_wr_data, rx_data});
                        if (byte_cnt == DB_LAST) begin
                            byte_cnt <= '0;
                            rx_rdy   <= 1'b0;
                            lb_wr_en <= 1'b1;
                            state    <= StIssue;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end

                StIssue: begin
                    to_cnt <= '0;
                    state  <= StWait;
                end

                StWait: begin
                    // A matching valid takes priority over the final timeout cycle.
                    if (is_wr ? lb_wr_valid : lb_rd_valid) begin
                        tx_valid <= 1'b1;
                        state    <= StResp;
                        if (is_wr) begin
                            tx_data   <= RSP_WR;
                            resp_left <= '0;
                        end else begin
                            tx_data   <= RSP_RD;
                            resp_sr   <= lb_rd_data;
                            resp_left <= DB_CNT;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        tx_valid  <= 1'b1;
                        tx_data   <= RSP_TO;
                        resp_left <= '0;
                        err_cnt   <= err_inc;
                        state     <= StResp;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end

                StResp: begin
                    if (tx_fire) begin
                        if (resp_left == 8'd0) begin
                            tx_valid <= 1'b0;
                            rx_rdy   <= 1'b1;
                            busy     <= 1'b0;
                            state    <= StIdle;
                        end else begin
                            tx_data   <= resp_sr[LB_DATA_W-1 -: 8];
                            resp_sr   <= resp_sr << 8;
                            resp_left <= resp_left - 8'd1;
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_cmd_bridge.sv
// Scoreboard bench for lb_cmd_bridge: stimulus pushes expected bus transactions,
// response bytes and strobe-to-response latencies; a monitor pops and compares.
module tb_lb_cmd_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        lb_wr_en;
    logic        lb_rd_en;
    logic [15:0] lb_addr;
    logic [31:0] lb_wr_data;
    logic        lb_wr_valid;
    logic        lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        busy;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    lb_cmd_bridge #(
        .LB_DATA_W      (32),
        .LB_ADDR_W      (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .lb_wr_en    (lb_wr_en),
        .lb_rd_en    (lb_rd_en),
        .lb_addr     (lb_addr),
        .lb_wr_data  (lb_wr_data),
        .lb_wr_valid (lb_wr_valid),
        .lb_rd_valid (lb_rd_valid),
        .lb_rd_data  (lb_rd_data),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          exp_lat[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          rsp_delay = 1;
    logic [31:0] rsp_rdata = '0;
    bit          rsp_active = 1'b0;
    bit          rdy_random = 1'b0;
    int          err_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink readiness: always ready or random.
    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_rdy = rdy_random ? ($urandom_range(0, 99) < 55) : 1'b1;
        end
    end

    // Bus slave: on a strobe at cycle S, return the matching valid in cycle S+rsp_delay.
    // A non-matching valid is pulsed at S+1 when there is room, and rd_data is junk
    // except when qualified.
    initial begin
        bit r_wr;
        int r_d;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (lb_wr_en || lb_rd_en)) begin
                r_wr = lb_wr_en;
                r_d  = rsp_delay;
                rsp_active = 1'b1;
                for (int k = 1; k <= r_d; k++) begin
                    @(posedge clk);
                    #1;
                    lb_rd_data = $urandom;
                    if (k == r_d) begin
                        lb_wr_valid = r_wr;
                        lb_rd_valid = !r_wr;
                        if (!r_wr) lb_rd_data = rsp_rdata;
                    end else if (k == 1) begin
                        lb_wr_valid = !r_wr;
                        lb_rd_valid = r_wr;
                    end else begin
                        lb_wr_valid = 1'b0;
                        lb_rd_valid = 1'b0;
                    end
                end
                @(posedge clk);
                #1;
                lb_wr_valid = 1'b0;
                lb_rd_valid = 1'b0;
                rsp_active  = 1'b0;
            end
        end
    end

    // Monitor: strobes, response bytes, latency, hold-under-backpressure, rx_rdy gating.
    initial begin
        bus_t       e;
        bit         pend;
        int unsigned s_cyc;
        int         lat;
        bit         prev_stb;
        bit         prev_hold;
        bit         prev_txv;
        logic [7:0] prev_data;
        pend = 0; prev_stb = 0; prev_hold = 0; prev_txv = 0; prev_data = '0; lat = 0; s_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; prev_stb = 0; prev_hold = 0; prev_txv = 0;
            end else begin
                if (prev_stb) check("strobe_single_cycle", {lb_wr_en, lb_rd_en}, 0);
                if (lb_wr_en || lb_rd_en) begin
                    check("strobe_expected", exp_bus.size() != 0, 1);
                    if (exp_bus.size() != 0) begin
                        e = exp_bus.pop_front();
                        check("strobe_type", {lb_wr_en, lb_rd_en}, e.wr ? 2'b10 : 2'b01);
                        check("lb_addr", lb_addr, e.addr);
                        if (e.wr) check("lb_wr_data", lb_wr_data, e.data);
                        lat   = exp_lat.pop_front();
                        pend  = 1;
                        s_cyc = cyc;
                    end
                end
                if (tx_valid && !prev_txv && pend) begin
                    check("resp_latency", cyc - s_cyc, lat);
                    pend = 0;
                end
                if (prev_hold) begin
                    check("tx_hold_valid", tx_valid, 1);
                    check("tx_hold_data", tx_data, prev_data);
                end
                if (tx_valid) check("rx_rdy_during_resp", rx_rdy, 0);
                if (tx_valid && tx_rdy) begin
                    check("tx_byte_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) check("tx_byte", tx_data, exp_tx.pop_front());
                end
                prev_stb  = lb_wr_en || lb_rd_en;
                prev_hold = tx_valid && !tx_rdy;
                prev_txv  = tx_valid;
                prev_data = tx_data;
            end
        end
    end

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_byte_accepted", rx_rdy, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_tx.size() != 0 || busy || rsp_active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_completes", n < 300, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_rx_rdy", rx_rdy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wr_en", lb_wr_en, 0);
        check("rst_rd_en", lb_rd_en, 0);
        check("rst_lb_addr", lb_addr, 0);
        check("rst_lb_wr_data", lb_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
    endtask

    task automatic bump_err();
        if (err_exp < 255) err_exp++;
    endtask

    // kind: 0 write, 1 read, 2 bad opcode (op). d: cycles from strobe to valid.
    task automatic do_frame(input int kind, input logic [7:0] op, input logic [15:0] addr,
                            input logic [31:0] data, input int d, input logic [31:0] rdata);
        bus_t e;
        rsp_delay = d;
        rsp_rdata = rdata;
        if (kind == 2) begin
            exp_tx.push_back(8'h45);
            bump_err();
        end else begin
            e.wr   = (kind == 0);
            e.addr = addr;
            e.data = data;
            exp_bus.push_back(e);
            exp_lat.push_back(d <= T ? d + 1 : T + 1);
            if (d > T) begin
                exp_tx.push_back(8'h54);
                bump_err();
            end else if (kind == 0) begin
                exp_tx.push_back(8'h4B);
            end else begin
                exp_tx.push_back(8'h44);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[i*8 +: 8]);
            end
        end
        if (kind == 2) begin
            send_byte(op);
        end else begin
            send_byte(kind == 0 ? 8'h57 : 8'h52);
            gap();
            send_byte(addr[15:8]);
            gap();
            send_byte(addr[7:0]);
            if (kind == 0) begin
                for (int i = 3; i >= 0; i--) begin
                    gap();
                    send_byte(data[i*8 +: 8]);
                end
            end
        end
        wait_idle();
        check("err_cnt", err_cnt, err_exp);
        if (kind != 2) check("lb_addr_held", lb_addr, addr);
        if (kind == 0) check("lb_wr_data_held", lb_wr_data, data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] a;
        logic [31:0] dw;
        int          kind;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_rdy_first_cycle", rx_rdy, 0);
        @(negedge clk);
        check("rx_rdy_second_cycle", rx_rdy, 1);
        @(posedge clk);
        #1;

        // Directed frames.
        do_frame(0, 8'h00, 16'h0012, 32'hDEADBEEF, 2, 32'h0);
        do_frame(1, 8'h00, 16'h0340, 32'h0, 3, 32'hCAFEF00D);
        do_frame(1, 8'h00, 16'h0100, 32'h0, 20, 32'h12345678);
        do_frame(2, 8'h33, 16'h0, 32'h0, 1, 32'h0);
        do_frame(1, 8'h00, 16'h0000, 32'h0, 1, 32'h0BADF00D);
        do_frame(0, 8'h00, 16'hBEEF, 32'h01020304, 1, 32'h0);
        do_frame(0, 8'h00, 16'hA5A5, 32'h89ABCDEF, T, 32'h0);
        do_frame(1, 8'h00, 16'h5A5A, 32'h0, T + 1, 32'h11223344);
        rdy_random = 1'b1;
        do_frame(1, 8'h00, 16'h7777, 32'h0, 2, 32'hF00DFACE);
        do_frame(1, 8'h00, 16'h1234, 32'h0, 5, 32'h80FF017E);

        // Reset in the middle of a write frame.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        err_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rx_rdy_after_midframe_rst", rx_rdy, 0);
        @(negedge clk);
        check("rx_rdy_up_after_midframe_rst", rx_rdy, 1);
        repeat (30) @(negedge clk);
        check("no_activity_after_rst", {busy, tx_valid}, 0);
        @(posedge clk);
        #1;
        do_frame(0, 8'h00, 16'h0042, 32'h5555AAAA, 3, 32'h0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 4) ? 0 : (kind < 8) ? 1 : 2;
            op = 8'($urandom);
            while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
            a  = 16'($urandom);
            dw = $urandom;
            rdy_random = ($urandom_range(0, 1) == 1);
            do_frame(kind, op, a, dw, $urandom_range(1, T + 4), $urandom);
        end

        repeat (5) @(posedge clk);
        check("queues_drained", exp_tx.size() + exp_bus.size() + exp_lat.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
